// File: rtl/systolic_job_scheduler.sv
// systolic_job_scheduler: queues matrix-multiply descriptors and launches them one at a time into the systolic controller under a watchdog.
module systolic_job_scheduler #(
  parameter int N              = 4,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [11:0]                  push_addr_a,
  input  logic [11:0]                  push_addr_b,
  input  logic [11:0]                  push_addr_c,
  input  logic [3:0]                   push_n,
  output logic                         push_err,
  input  logic                         acc_idle,
  output logic                         acc_start,
  output logic [11:0]                  acc_addr_a,
  output logic [11:0]                  acc_addr_b,
  output logic [11:0]                  acc_addr_c,
  output logic [3:0]                   acc_n,
  output logic                         busy,
  output logic [7:0]                   jobs_done,
  output logic                         timeout,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, WAIT_ACK = 3'd2, RUN = 3'd3, DONE = 3'd4, HALT = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [WW-1:0] wd_q, wd_d;
  logic [39:0]   mem_q [DEPTH];
  logic [39:0]   acc_q;
  logic [7:0]    done_q;
  logic          err_q;
  logic          n_ok, push_go, pop, launch_go, wd_hit;

  assign push_ready = cnt_q != CW'(DEPTH);
  assign n_ok       = push_n != 4'd0 && push_n <= 4'(N);
  assign push_go    = push_valid && push_ready && n_ok;
  assign pop        = state_q == LAUNCH;
  assign launch_go  = state_q == IDLE && cnt_q != '0 && acc_idle;
  // the watchdog spans WAIT_ACK and RUN together; the normal transition wins a tie
  assign wd_hit     = wd_q + WW'(1) == WW'(TIMEOUT_CYCLES);

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE:     state_d = launch_go ? LAUNCH : IDLE;
      LAUNCH: begin
        state_d = WAIT_ACK;
        wd_d    = '0;
      end
      WAIT_ACK: begin
        wd_d    = wd_q + WW'(1);
        state_d = !acc_idle ? RUN : wd_hit ? HALT : WAIT_ACK;
      end
      RUN: begin
        wd_d    = wd_q + WW'(1);
        state_d = acc_idle ? DONE : wd_hit ? HALT : RUN;
      end
      DONE:     state_d = IDLE;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      acc_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= push_valid && push_ready && !n_ok;
      cnt_q   <= cnt_q + CW'(push_go) - CW'(pop);
      if (push_go) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      if (launch_go) acc_q <= mem_q[rd_q];
      if (state_q == DONE) done_q <= done_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_go) mem_q[wr_q] <= {push_addr_a, push_addr_b, push_addr_c, push_n};
  end

  assign {acc_addr_a, acc_addr_b, acc_addr_c, acc_n} = acc_q;
  assign acc_start   = state_q == LAUNCH;
  assign busy        = state_q == LAUNCH || state_q == WAIT_ACK || state_q == RUN || state_q == DONE;
  assign timeout     = state_q == HALT;
  assign jobs_done   = done_q;
  assign push_err    = err_q;
  assign queue_count = cnt_q;
endmodule

// File: tb/tb_systolic_job_scheduler.sv
// tb_systolic_job_scheduler: directed scenarios plus randomized traffic, checked every cycle against a queue-based job model.
module tb_systolic_job_scheduler;
  localparam int N = 4, DEPTH = 4, TMO = 1024;

  logic        clk = 0, rst_n = 1;
  logic        push_valid = 0, acc_idle = 1;
  logic [11:0] push_addr_a = 0, push_addr_b = 0, push_addr_c = 0;
  logic [3:0]  push_n = 0;
  logic        push_ready, push_err, acc_start, busy, timeout;
  logic [11:0] acc_addr_a, acc_addr_b, acc_addr_c;
  logic [3:0]  acc_n;
  logic [7:0]  jobs_done;
  logic [2:0]  queue_count;

  systolic_job_scheduler #(.N(N), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(push_ready),
    .push_addr_a(push_addr_a), .push_addr_b(push_addr_b), .push_addr_c(push_addr_c),
    .push_n(push_n), .push_err(push_err), .acc_idle(acc_idle), .acc_start(acc_start),
    .acc_addr_a(acc_addr_a), .acc_addr_b(acc_addr_b), .acc_addr_c(acc_addr_c), .acc_n(acc_n),
    .busy(busy), .jobs_done(jobs_done), .timeout(timeout), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_LAUNCH, M_WAIT, M_RUN, M_DONE, M_HALT} ph_t;
  typedef struct packed { logic [11:0] a, b, c; logic [3:0] n; } desc_t;

  desc_t q[$];
  desc_t cur;
  ph_t   ph;
  int    wcount, done_cnt;
  bit    err;
  int    n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    cur = '0; ph = M_IDLE; wcount = 0; done_cnt = 0; err = 0;
  endtask

  // job-level model: one clock edge of queue, launch and completion rules
  task automatic model_edge();
    int  sz = q.size();
    bit  room = sz < DEPTH;
    bit  bad = push_n == 0 || push_n > N;
    err = push_valid && room && bad;
    case (ph)
      M_IDLE:   if (sz > 0 && acc_idle) begin ph = M_LAUNCH; cur = q[0]; end
      M_LAUNCH: begin void'(q.pop_front()); ph = M_WAIT; wcount = 0; end
      M_WAIT:   begin wcount++; if (!acc_idle) ph = M_RUN; else if (wcount == TMO) ph = M_HALT; end
      M_RUN:    begin wcount++; if (acc_idle) ph = M_DONE; else if (wcount == TMO) ph = M_HALT; end
      M_DONE:   begin done_cnt = (done_cnt + 1) % 256; ph = M_IDLE; end
      default:  ;
    endcase
    if (push_valid && room && !bad) q.push_back({push_addr_a, push_addr_b, push_addr_c, push_n});
  endtask

  task automatic check_all();
    chk("acc_start", acc_start, ph == M_LAUNCH);
    chk("busy", busy, ph inside {M_LAUNCH, M_WAIT, M_RUN, M_DONE});
    chk("timeout", timeout, ph == M_HALT);
    chk("push_ready", push_ready, q.size() < DEPTH);
    chk("push_err", push_err, err);
    chk("queue_count", queue_count, q.size());
    chk("jobs_done", jobs_done, done_cnt);
    chk("acc_desc", {acc_addr_a, acc_addr_b, acc_addr_c, acc_n}, cur);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1 check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 m_reset();
    check_all();
    repeat (2) tick();
    #2 rst_n = 1;
  endtask

  task automatic push(input logic [11:0] a, b, c, input logic [3:0] n);
    push_valid = 1; push_addr_a = a; push_addr_b = b; push_addr_c = c; push_n = n;
    tick();
    push_valid = 0;
  endtask

  task automatic run_job(input logic [11:0] ea, input int hold);
    int w = 0;
    acc_idle = 1;
    while (acc_start !== 1'b1 && w < 10) begin tick(); w++; end
    chk("start_seen", acc_start, 1);
    chk("order_a", acc_addr_a, ea);
    tick(); tick();
    acc_idle = 0;
    repeat (hold) tick();
    acc_idle = 1;
    tick(); tick();
  endtask

  initial begin
    int lag, hold, w;
    lag = 0; hold = 0;
    #1 rst_n = 0;
    #2 m_reset();
    check_all();
    repeat (2) tick();
    #2 rst_n = 1;

    // launch latency and descriptor delivery
    push(12'h000, 12'h010, 12'h020, 4'd4);
    chk("t1_no_start_yet", acc_start, 0);
    tick();
    chk("t1_start", acc_start, 1);
    chk("t1_addr_c", acc_addr_c, 12'h020);
    chk("t1_n", acc_n, 4);
    chk("t1_busy", busy, 1);
    run_job(12'h000, 40);
    chk("t2_jobs_done", jobs_done, 1);
    chk("t2_busy", busy, 0);

    // fill the FIFO while the controller is unavailable, then drain across the pointer wrap
    acc_idle = 0;
    for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 12'h200, 12'h300, 4'(i % 4 + 1));
    chk("t3_ready_full", push_ready, 0);
    chk("t3_count_full", queue_count, 4);
    push(12'h1ff, 12'h200, 12'h300, 4'd2);
    chk("t3_count_after_5th", queue_count, 4);
    chk("t3_no_err_full", push_err, 0);
    for (int i = 0; i < 4; i++) run_job(12'h100 + 12'(i), 5);
    chk("t3_jobs_done", jobs_done, 5);

    // illegal sizes are rejected with a one-cycle error
    push(12'h111, 12'h222, 12'h333, 4'd0);
    chk("t4_err_n0", push_err, 1);
    push(12'h111, 12'h222, 12'h333, 4'd5);
    chk("t4_err_n5", push_err, 1);
    tick();
    chk("t4_err_clear", push_err, 0);
    chk("t4_count", queue_count, 0);
    chk("t4_no_start", acc_start, 0);

    // randomized traffic with a controller that goes busy shortly after each start
    for (int c = 0; c < 800; c++) begin
      push_valid  = 1'($urandom_range(0, 1));
      push_n      = 4'($urandom_range(0, 6));
      push_addr_a = 12'($urandom); push_addr_b = 12'($urandom); push_addr_c = 12'($urandom);
      if (ph == M_LAUNCH) begin lag = $urandom_range(0, 2); hold = $urandom_range(1, 15); end
      else if (lag > 0) lag--;
      else if (hold > 0) hold--;
      acc_idle = !(lag == 0 && hold > 0);
      tick();
    end
    push_valid = 0;
    acc_idle = 1;
    do_reset();

    // watchdog expiry halts the scheduler; queued jobs stay put until reset
    push(12'h0a0, 12'h0b0, 12'h0c0, 4'd2);
    tick();
    chk("t5_start", acc_start, 1);
    acc_idle = 0;
    push(12'h0a1, 12'h0b1, 12'h0c1, 4'd3);
    push(12'h0a2, 12'h0b2, 12'h0c2, 4'd1);
    w = 0;
    while (timeout !== 1'b1 && w < TMO + 50) begin tick(); w++; end
    chk("t5_timeout", timeout, 1);
    chk("t5_busy", busy, 0);
    acc_idle = 1;
    repeat (5) tick();
    chk("t5_no_launch", acc_start, 0);
    chk("t5_queued", queue_count, 2);
    do_reset();
    chk("t5_timeout_cleared", timeout, 0);

    // asynchronous reset in the middle of a running job
    push(12'h0d0, 12'h0e0, 12'h0f0, 4'd4);
    push(12'h0d1, 12'h0e1, 12'h0f1, 4'd4);
    push(12'h0d2, 12'h0e2, 12'h0f2, 4'd4);
    acc_idle = 0;
    tick(); tick();
    chk("t6_busy_run", busy, 1);
    chk("t6_queued", queue_count, 2);
    #2 rst_n = 0;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_count", queue_count, 0);
    chk("t6_async_addr", acc_addr_a, 0);
    m_reset();
    check_all();
    repeat (2) tick();
    #2 rst_n = 1;
    acc_idle = 1;
    repeat (5) tick();
    chk("t6_no_start", acc_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1);
  end
endmodule
